// File: rtl/plic_pkg.sv
// plic_pkg: shared gateway state encoding and defaults
package plic_pkg;
  typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_INFLIGHT} gw_state_e;
  localparam int NUM_SRC_DEFAULT = 2;
endpackage

// File: rtl/irq_gate_ch.sv
// irq_gate_ch: one button channel with sync, debounce, edge count and request/claim/complete FSM
module irq_gate_ch
  import plic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic claim,
  input  logic complete,
  output logic irq
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2, stable, stable_q, rise, leave;
  logic [DB_W-1:0] db_cnt;
  logic [CNT_W-1:0] pend_cnt;
  gw_state_e state, state_n;
  always_comb begin
    rise = stable & ~stable_q;
    leave = state == GW_IDLE && pend_cnt != '0;
    state_n = leave ? GW_PENDING
            : state == GW_PENDING && claim ? GW_INFLIGHT
            : state == GW_INFLIGHT && complete ? GW_IDLE : state;
  end
  assign irq = state == GW_PENDING;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      stable <= 1'b0;
      stable_q <= 1'b0;
      db_cnt <= '0;
      pend_cnt <= '0;
      state <= GW_IDLE;
    end else begin
      s1 <= btn;
      s2 <= s1;
      stable_q <= stable;
      if (s2 == stable) db_cnt <= '0;
      else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + DB_W'(1);
      pend_cnt <= rise == leave ? pend_cnt
                : rise ? (&pend_cnt ? pend_cnt : pend_cnt + CNT_W'(1))
                : pend_cnt - CNT_W'(1);
      state <= state_n;
    end
  end
endmodule

// File: rtl/irq_gateway.sv
// irq_gateway: independent button-to-PLIC request channels, one per source
module irq_gateway
  import plic_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 2
) (
  input  logic               CLK100MHZ,
  input  logic               BTNC,
  input  logic [NUM_SRC-1:0] btn_i,
  output logic [NUM_SRC-1:0] irq_o,
  input  logic [NUM_SRC-1:0] claim_i,
  input  logic [NUM_SRC-1:0] complete_i
);
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    irq_gate_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(CLK100MHZ),
      .rst(BTNC),
      .btn(btn_i[i]),
      .claim(claim_i[i]),
      .complete(complete_i[i]),
      .irq(irq_o[i])
    );
  end
endmodule

// File: tb/tb_irq_gateway.sv
// tb_irq_gateway: directed and random checks of irq_gateway against a window-based reference model
module tb_irq_gateway;
  localparam int N = 2, D = 4, W = 2, MAXP = 3, H = D + 2;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] btn, irq, claim, complete;
  int checks = 0, errors = 0;
  int hist [N][H];
  int m_stable [N], m_rose [N], m_pend [N], m_st [N];
  irq_gateway #(.NUM_SRC(N), .DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
    .CLK100MHZ(clk),
    .BTNC(rst),
    .btn_i(btn),
    .irq_o(irq),
    .claim_i(claim),
    .complete_i(complete)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    for (int s = 0; s < N; s++) begin
      int leave, inc, ns;
      bit acc;
      if (rst) begin
        for (int j = 0; j < H; j++) hist[s][j] = 0;
        m_stable[s] = 0;
        m_rose[s] = 0;
        m_pend[s] = 0;
        m_st[s] = 0;
      end else begin
        leave = (m_st[s] == 0 && m_pend[s] != 0) ? 1 : 0;
        inc = (m_rose[s] != 0 && (leave != 0 || m_pend[s] < MAXP)) ? 1 : 0;
        m_pend[s] = m_pend[s] + inc - leave;
        if (leave != 0) m_st[s] = 1;
        else if (m_st[s] == 1 && claim[s]) m_st[s] = 2;
        else if (m_st[s] == 2 && complete[s]) m_st[s] = 0;
        for (int j = H - 1; j > 0; j--) hist[s][j] = hist[s][j-1];
        hist[s][0] = int'(btn[s]);
        acc = 1'b1;
        for (int j = 2; j < H; j++) if (hist[s][j] == m_stable[s]) acc = 1'b0;
        ns = acc ? 1 - m_stable[s] : m_stable[s];
        m_rose[s] = (ns == 1 && m_stable[s] == 0) ? 1 : 0;
        m_stable[s] = ns;
      end
    end
  end
  always @(negedge clk) begin
    check("irq0", int'(irq[0]), m_st[0] == 1 ? 1 : 0);
    check("irq1", int'(irq[1]), m_st[1] == 1 ? 1 : 0);
    check("pend0", int'(dut.g_ch[0].u_ch.pend_cnt), m_pend[0]);
    check("pend1", int'(dut.g_ch[1].u_ch.pend_cnt), m_pend[1]);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_claim(input int s);
    claim[s] = 1'b1;
    tick(1);
    claim[s] = 1'b0;
  endtask
  task automatic pulse_complete(input int s);
    complete[s] = 1'b1;
    tick(1);
    complete[s] = 1'b0;
  endtask
  task automatic press(input int s);
    btn[s] = 1'b1;
    tick(7);
    btn[s] = 1'b0;
    tick(7);
  endtask
  task automatic wait_irq(input int s, input int max);
    int n;
    n = 0;
    while (irq[s] !== 1'b1 && n < max) begin
      tick(1);
      n++;
    end
    if (irq[s] !== 1'b1) check("irq_timeout", 0, 1);
  endtask
  initial begin
    int n;
    rst = 1'b1;
    btn = '1;
    claim = '0;
    complete = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_irq", int'(irq), 0);
    end
    rst = 1'b0;
    n = 0;
    while (irq != 2'b11 && n < 20) begin
      tick(1);
      n++;
    end
    check("latency", n - 1, D + 3);
    claim = 2'b11;
    tick(1);
    claim = '0;
    check("claim_both", int'(irq), 0);
    complete = 2'b11;
    tick(1);
    complete = '0;
    tick(2);
    check("complete_both", int'(irq), 0);
    btn = '0;
    tick(10);
    check("fall_ignored", int'(irq), 0);
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(12);
    check("glitch_irq", int'(irq[0]), 0);
    check("glitch_pend", int'(dut.g_ch[0].u_ch.pend_cnt), 0);
    btn[0] = 1'b1;
    wait_irq(0, 20);
    pulse_complete(0);
    check("early_complete", int'(irq[0]), 1);
    pulse_claim(0);
    check("claim_drop", int'(irq[0]), 0);
    pulse_complete(0);
    tick(2);
    check("complete_idle", int'(irq[0]), 0);
    btn[0] = 1'b0;
    tick(8);
    press(0);
    wait_irq(0, 20);
    pulse_claim(0);
    for (int i = 0; i < 4; i++) press(0);
    check("sat_pend", int'(dut.g_ch[0].u_ch.pend_cnt), MAXP);
    for (int r = 0; r < 3; r++) begin
      pulse_complete(0);
      check("round_idle", int'(irq[0]), 0);
      tick(1);
      check("round_req", int'(irq[0]), 1);
      pulse_claim(0);
    end
    pulse_complete(0);
    tick(3);
    check("sat_drained", int'(irq[0]), 0);
    press(0);
    wait_irq(0, 20);
    pulse_claim(0);
    press(0);
    check("pre_sim_pend", int'(dut.g_ch[0].u_ch.pend_cnt), 1);
    btn[0] = 1'b1;
    tick(5);
    complete[0] = 1'b1;
    tick(1);
    complete[0] = 1'b0;
    tick(1);
    check("sim_pend", int'(dut.g_ch[0].u_ch.pend_cnt), 1);
    check("sim_irq", int'(irq[0]), 1);
    claim[0] = 1'b1;
    complete[0] = 1'b1;
    tick(1);
    claim[0] = 1'b0;
    complete[0] = 1'b0;
    check("claim_cmpl_irq", int'(irq[0]), 0);
    tick(3);
    check("claim_cmpl_infl", int'(irq[0]), 0);
    pulse_complete(0);
    tick(1);
    check("after_cc_req", int'(irq[0]), 1);
    pulse_claim(0);
    btn[0] = 1'b0;
    tick(8);
    press(0);
    press(0);
    check("pre_rst_pend", int'(dut.g_ch[0].u_ch.pend_cnt), 2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("post_rst_irq", int'(irq), 0);
    check("post_rst_pend", int'(dut.g_ch[0].u_ch.pend_cnt), 0);
    btn[0] = 1'b1;
    wait_irq(0, 20);
    btn[0] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++) begin
        if ($urandom_range(0, 7) == 0) btn[s] = ~btn[s];
        claim[s] = $urandom_range(0, 3) == 0;
        complete[s] = $urandom_range(0, 3) == 0;
      end
      tick(1);
    end
    claim = '0;
    complete = '0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
